uart_tx_arbiter: RTL and testbench

Shares one UART transmitter (the `uart_controller` TX path) between NUM_REQ independent byte sources. Requests are granted round-robin and each grant is held for a whole packet, so bytes from different sources never interleave on the serial line. Sits between the requesting client blocks and the transmitter's `i_Tx_Ready`/`i_Tx_Byte`/`o_Tx_Done` interface.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rr_picker.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 95 +++++++++
 tb/tb_uart_tx_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, requester limit and index helper for the UART TX arbiter
package uart_pkg;
    localparam int MAX_REQ = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, HOLD = 2'd3} state_t;
    function automatic logic [2:0] next_idx(input logic [2:0] idx, input int n);
        return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
    endfunction
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: rotate-priority encoder, first valid index at or above ptr, wrapping to the lowest
module uart_rr_picker import uart_pkg::*; #(
    parameter int N = 4
) (
    input  logic [N-1:0]                 valid,
    input  logic [$clog2(MAX_REQ)-1:0]   ptr,
    output logic                         found,
    output logic [$clog2(MAX_REQ)-1:0]   idx
);
    localparam int IW = $clog2(MAX_REQ);
    // Lowest set bit overall is the wrap-around fallback; a set bit at or above ptr overrides it.
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (valid[i]) begin
                found = 1'b1;
                idx = IW'(i);
            end
        for (int i = N - 1; i >= 0; i--)
            if (valid[i] && IW'(i) >= ptr)
                idx = IW'(i);
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter among NUM_REQ byte sources
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_byte,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_byte,
    input  logic                   tx_done,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   lock_abort
);
    localparam int IW = $clog2(MAX_REQ);
    localparam int HW = $clog2(HOLD_TIMEOUT);

    state_t          state;
    logic [IW-1:0]   rr_ptr, owner, pick_idx, sel;
    logic            last_q, found, accept, sel_valid, sel_last;
    logic [7:0]      sel_byte;
    logic [HW-1:0]   hold_cnt;

    uart_rr_picker #(.N(NUM_REQ)) picker (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick_idx)
    );

    // While a packet is locked only its owner is looked at.
    always_comb begin
        sel = (state == HOLD) ? owner : pick_idx;
        sel_valid = 1'b0;
        sel_last = 1'b0;
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (IW'(i) == sel) begin
                sel_valid = req_valid[i];
                sel_last = req_last[i];
                sel_byte = req_byte[8*i +: 8];
            end
        accept = !reset && ((state == IDLE) ? found : (state == HOLD) && sel_valid);
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = accept && IW'(i) == sel;
    end

    assign grant_id = owner;
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            last_q <= 1'b0;
            tx_byte <= '0;
            tx_start <= 1'b0;
            lock_abort <= 1'b0;
            hold_cnt <= '0;
        end else begin
            tx_start <= accept;
            lock_abort <= 1'b0;
            if (accept) begin
                tx_byte <= sel_byte;
                last_q <= sel_last;
                owner <= sel;
            end
            case (state)
                IDLE:  state <= accept ? START : IDLE;
                START: state <= BUSY;
                BUSY:
                    if (tx_done) begin
                        state <= last_q ? IDLE : HOLD;
                        hold_cnt <= '0;
                        if (last_q)
                            rr_ptr <= next_idx(owner, NUM_REQ);
                    end
                HOLD:
                    if (accept)
                        state <= START;
                    else if (hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                        lock_abort <= 1'b1;
                        rr_ptr <= next_idx(owner, NUM_REQ);
                        state <= IDLE;
                    end else
                        hold_cnt <= hold_cnt + 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench; requesters feed byte queues, a monitor checks every tx_start
module tb_uart_tx_arbiter;
    logic        clk = 0, reset = 0;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_byte;
    logic        tx_start, tx_done, busy, lock_abort;
    logic [7:0]  tx_byte;
    logic [2:0]  grant_id;

    int total = 0, bad = 0, cyc = 0, done_cyc = 0, frame = 12;
    bit have_done = 0, gap_check = 0;
    logic [10:0] sb [$];
    logic [10:0] want;
    logic [8:0]  src_mem [4][16];
    int head [4], tail [4];

    uart_tx_arbiter #(.NUM_REQ(4), .HOLD_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_byte   (req_byte),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .grant_id   (grant_id),
        .busy       (busy),
        .lock_abort (lock_abort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic send(input int r, input logic [7:0] b, input logic l);
        src_mem[r][tail[r] % 16] = {l, b};
        tail[r]++;
    endtask

    task automatic exp_tx(input int r, input logic [7:0] b);
        sb.push_back({3'(r), b});
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = head[i] != tail[i];
            {req_last[i], req_byte[8*i +: 8]} = req_valid[i] ? src_mem[i][head[i] % 16] : 9'h0;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && head[0] == tail[0] && head[1] == tail[1] &&
                head[2] == tail[2] && head[3] == tail[3]) return;
        end
        fail(name);
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (tx_done) return;
        end
        fail(name);
    endtask

    // Requester sources: a byte leaves its queue only when req_ready was seen for it.
    initial begin
        logic [3:0] rdy;
        drive();
        forever begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++)
                if (rdy[i] && head[i] != tail[i]) head[i]++;
            drive();
        end
    end

    // Transmitter model: tx_done pulses frame cycles after tx_start.
    initial begin
        int cnt;
        cnt = 0;
        tx_done = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 0;
            if (reset) cnt = 0;
            else if (tx_start) cnt = frame;
            else if (cnt > 0) begin
                cnt--;
                tx_done = cnt == 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (req_ready != 0) check("ready_onehot", 32'($onehot(req_ready)), 1);
            if (tx_start) begin
                if (sb.size() == 0) fail("sb_underflow");
                else begin
                    want = sb.pop_front();
                    check("tx_byte", tx_byte, want[7:0]);
                    check("grant_id", grant_id, want[10:8]);
                end
                if (gap_check && have_done) check("start_gap", cyc - done_cyc, 2);
            end
            if (tx_done) begin
                done_cyc = cyc;
                have_done = 1;
            end
        end
    end

    initial begin
        bit seen;
        #1 reset = 1;
        #2;
        check("rst_ready", req_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_abort", lock_abort, 0);
        repeat (3) @(negedge clk);
        reset = 0;

        send(0, 8'h01, 1); send(1, 8'h10, 1); send(3, 8'h22, 1);
        exp_tx(0, 8'h01); exp_tx(1, 8'h10); exp_tx(3, 8'h22);
        wait_idle("contention", 300);

        send(0, 8'h21, 0); send(0, 8'h11, 0); send(0, 8'h32, 1); send(1, 8'hFF, 1);
        exp_tx(0, 8'h21); exp_tx(0, 8'h11); exp_tx(0, 8'h32); exp_tx(1, 8'hFF);
        wait_idle("packet_lock", 300);

        send(2, 8'h55, 0); send(2, 8'hAA, 1);
        exp_tx(2, 8'h55); exp_tx(2, 8'hAA);
        wait_done("single_done1", 100);
        wait_done("single_done2", 100);
        check("busy_at_done", busy, 1);
        @(negedge clk);
        check("busy_drop", busy, 0);
        wait_idle("single", 100);

        // rr_ptr must now be 3: requester 3 beats requester 2
        send(3, 8'h33, 1); send(2, 8'h2C, 1);
        exp_tx(3, 8'h33); exp_tx(2, 8'h2C);
        wait_idle("rr_ptr3", 300);

        send(1, 8'h77, 0); send(2, 8'h5A, 1);
        exp_tx(1, 8'h77); exp_tx(2, 8'h5A);
        wait_done("t77_done", 100);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = lock_abort;
        end
        if (!seen) fail("lock_abort");
        else begin
            check("abort_delay", cyc - done_cyc, 17);
            check("abort_busy", busy, 0);
            @(negedge clk);
            check("abort_pulse", lock_abort, 0);
        end
        wait_idle("timeout", 300);

        send(3, 8'hC3, 1);
        exp_tx(3, 8'hC3);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = tx_start;
        end
        if (!seen) fail("c3_start");
        repeat (3) @(negedge clk);
        check("busy_before_rst", busy, 1);
        #2 reset = 1;
        #1;
        check("arst_tx_start", tx_start, 0);
        check("arst_busy", busy, 0);
        check("arst_grant", grant_id, 0);
        check("arst_tx_byte", tx_byte, 0);
        check("arst_ready", req_ready, 0);
        check("arst_abort", lock_abort, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        send(3, 8'h3C, 1); send(0, 8'h0C, 1);
        exp_tx(0, 8'h0C); exp_tx(3, 8'h3C);
        wait_idle("restart", 300);

        frame = 2170;
        have_done = 0;
        gap_check = 1;
        for (int k = 0; k < 8; k++) begin
            send(1, 8'(8'h80 + k), 1);
            exp_tx(1, 8'(8'h80 + k));
        end
        wait_idle("back_to_back", 20000);
        gap_check = 0;
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
